// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: first-word-fall-through result queue in front of the common data bus.
// Optional same-cycle empty-FIFO bypass is enabled by defining CDB_FIFO_BYPASS_EN.
module cdb_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     cdb_grant,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] NO_TAG = '1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              wr_ok, pop, push, store;
  assign empty    = count_q == '0;
  assign full     = count_q == FULL_CNT;
  assign count    = count_q;
  assign overflow = ovf_q;
  always_comb begin
    wr_ok = wr_en && wr_tag != NO_TAG;
    pop   = cdb_grant && !empty;
    push  = wr_ok && (!full || pop);
`ifdef CDB_FIFO_BYPASS_EN
    // A result granted while bypassing an empty queue never touches storage
    store     = push && !(empty && cdb_grant);
    cdb_valid = !empty || wr_ok;
    cdb_tag   = !empty ? tag_q[rptr_q]  : wr_ok ? wr_tag  : NO_TAG;
    cdb_data  = !empty ? data_q[rptr_q] : wr_ok ? wr_data : '0;
`else
    store     = push;
    cdb_valid = !empty;
    cdb_tag   = empty ? NO_TAG : tag_q[rptr_q];
    cdb_data  = empty ? '0 : data_q[rptr_q];
`endif
    wptr_d  = wptr_q + AW'(store);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(store) - (AW+1)'(pop);
    ovf_d   = ovf_q | (wr_ok && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (store && !reset) begin
      data_q[wptr_q] <= wr_data;
      tag_q[wptr_q]  <= wr_tag;
    end
  end
endmodule

// File: tb/tb_cdb_result_fifo.sv
// tb_cdb_result_fifo: directed self-checking bench for cdb_result_fifo (DEPTH=8, DATA_W=32, TAG_W=4).
module tb_cdb_result_fifo;
  logic        clk = 1'b0;
  logic        reset, wr_en, cdb_grant;
  logic [3:0]  wr_tag;
  logic [31:0] wr_data;
  logic        cdb_valid, full, empty, overflow;
  logic [3:0]  cdb_tag, count;
  logic [31:0] cdb_data;
  int checks = 0;
  int failures = 0;

  cdb_result_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data),
    .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr_en = 0; cdb_grant = 0; wr_tag = 0; wr_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); reset = 0;
  endtask

  task automatic write(input logic [3:0] t, input logic [31:0] d);
    wr_en = 1; wr_tag = t; wr_data = d; tick(); idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({empty, full, count, cdb_valid, cdb_tag, cdb_data, overflow} !== {1'b1, 1'b0, 4'd0, 1'b0, 4'hF, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got e=%b f=%b c=%0d v=%b t=%h d=%h o=%b want e=1 f=0 c=0 v=0 t=f d=0 o=0",
               empty, full, count, cdb_valid, cdb_tag, cdb_data, overflow);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    wr_en = 1; wr_tag = 4'd3; wr_data = 32'h5; #1;
    checks++;
`ifdef CDB_FIFO_BYPASS_EN
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd3, 32'h5}) begin
`else
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b0, 4'hF, 32'h0}) begin
`endif
      failures++;
      $display("FAIL write_cycle_head: got v=%b t=%h d=%h", cdb_valid, cdb_tag, cdb_data);
    end
    tick(); idle();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data, count} !== {1'b1, 4'd3, 32'h5, 4'd1}) begin
      failures++;
      $display("FAIL single_write: got v=%b t=%h d=%h c=%0d want v=1 t=3 d=5 c=1", cdb_valid, cdb_tag, cdb_data, count);
    end
    cdb_grant = 1; tick(); idle();
    checks++;
    if ({empty, cdb_valid, cdb_tag} !== {1'b1, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL single_pop: got e=%b v=%b t=%h want e=1 v=0 t=f", empty, cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) write(4'(i), 32'd100 + 32'(i));
    checks++;
    if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
      failures++;
      $display("FAIL fill_full: got f=%b c=%0d o=%b want f=1 c=8 o=0", full, count, overflow);
    end
    write(4'd9, 32'hDEAD);
    checks++;
    if ({full, count, overflow} !== {1'b1, 4'd8, 1'b1}) begin
      failures++;
      $display("FAIL overflow_drop: got f=%b c=%0d o=%b want f=1 c=8 o=1", full, count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'(i), 32'd100 + 32'(i)}) begin
        failures++;
        $display("FAIL drain_order[%0d]: got v=%b t=%h d=%0d want v=1 t=%h d=%0d", i, cdb_valid, cdb_tag, cdb_data, i, 100 + i);
      end
      cdb_grant = 1; tick(); idle();
    end
    checks++;
    if ({empty, count, overflow} !== {1'b1, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL overflow_sticky: got e=%b c=%0d o=%b want e=1 c=0 o=1", empty, count, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [3:0]  exp_t;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 8; i++) write(4'(i), 32'd200 + 32'(i));
    wr_en = 1; wr_tag = 4'd2; wr_data = 32'hAA; cdb_grant = 1; tick(); idle();
    checks++;
    if ({count, full, overflow, cdb_tag, cdb_data} !== {4'd8, 1'b1, 1'b0, 4'd1, 32'd201}) begin
      failures++;
      $display("FAIL full_push_pop: got c=%0d f=%b o=%b t=%h d=%0d want c=8 f=1 o=0 t=1 d=201",
               count, full, overflow, cdb_tag, cdb_data);
    end
    for (int i = 1; i < 9; i++) begin
      exp_t = (i == 8) ? 4'd2 : 4'(i);
      exp_d = (i == 8) ? 32'hAA : 32'd200 + 32'(i);
      checks++;
      if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, exp_t, exp_d}) begin
        failures++;
        $display("FAIL full_pp_order[%0d]: got t=%h d=%h want t=%h d=%h", i, cdb_tag, cdb_data, exp_t, exp_d);
      end
      cdb_grant = 1; tick(); idle();
    end
    checks++;
    if ({empty, overflow} !== 2'b10) begin
      failures++;
      $display("FAIL full_pp_end: got e=%b o=%b want e=1 o=0", empty, overflow);
    end
  endtask

  task automatic test_empty_grant_notag();
    do_reset();
    cdb_grant = 1; tick(); idle();
    checks++;
    if ({empty, count, cdb_valid, cdb_tag} !== {1'b1, 4'd0, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL empty_grant: got e=%b c=%0d v=%b t=%h want e=1 c=0 v=0 t=f", empty, count, cdb_valid, cdb_tag);
    end
    wr_en = 1; wr_tag = 4'hF; wr_data = 32'h77; #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b0, 4'hF, 32'd0}) begin
      failures++;
      $display("FAIL notag_head: got v=%b t=%h d=%h want v=0 t=f d=0", cdb_valid, cdb_tag, cdb_data);
    end
    tick(); idle();
    checks++;
    if ({count, overflow, cdb_valid} !== {4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL notag_write: got c=%0d o=%b v=%b want c=0 o=0 v=0", count, overflow, cdb_valid);
    end
    for (int i = 0; i < 8; i++) write(4'(i), 32'(i));
    write(4'hF, 32'h1);
    checks++;
    if ({count, overflow} !== {4'd8, 1'b0}) begin
      failures++;
      $display("FAIL notag_full: got c=%0d o=%b want c=8 o=0", count, overflow);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 0; i < 3; i++) write(4'(i + 1), 32'(i));
    reset = 1; wr_en = 1; wr_tag = 4'd5; wr_data = 32'h55; tick(); reset = 0; idle();
    checks++;
    if ({count, empty, overflow, cdb_valid, cdb_tag} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL reset_priority: got c=%0d e=%b o=%b v=%b t=%h want c=0 e=1 o=0 v=0 t=f",
               count, empty, overflow, cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) write(4'(i + r), 32'(r * 16 + i));
      for (int i = 0; i < 6; i++) begin
        checks++;
        if ({cdb_tag, cdb_data} !== {4'(i + r), 32'(r * 16 + i)}) begin
          failures++;
          $display("FAIL wrap[%0d][%0d]: got t=%h d=%h want t=%h d=%h", r, i, cdb_tag, cdb_data, 4'(i + r), r * 16 + i);
        end
        cdb_grant = 1; tick(); idle();
      end
    end
    checks++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL wrap_end: got e=%b c=%0d want e=1 c=0", empty, count);
    end
  endtask

`ifdef CDB_FIFO_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    wr_en = 1; wr_tag = 4'd6; wr_data = 32'h10; cdb_grant = 1; #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd6, 32'h10}) begin
      failures++;
      $display("FAIL bypass_head: got v=%b t=%h d=%h want v=1 t=6 d=10", cdb_valid, cdb_tag, cdb_data);
    end
    tick(); idle();
    checks++;
    if ({count, empty, cdb_valid} !== {4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL bypass_consumed: got c=%0d e=%b v=%b want c=0 e=1 v=0", count, empty, cdb_valid);
    end
  endtask
`endif

  initial begin
    reset = 1; idle();
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_grant_notag();
    test_reset_priority();
    test_wrap();
`ifdef CDB_FIFO_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_result_fifo.md
CDB_RESULT_FIFO -- requirements
Module: cdb_result_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, 2 or greater.
REQ-002 Parameter DATA_W, default 32, result width.
REQ-003 Parameter TAG_W, default 4, reservation-station tag width; the all-ones tag (4'b1111) is the "no tag" value.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  write request, driven by the functional unit's broadcast output.
REQ-007 wr_tag  in  TAG_W  tag of the producing reservation-station row.
REQ-008 wr_data  in  DATA_W  result value.
REQ-009 cdb_grant  in  1  CDB arbiter accepts the head entry this cycle.
REQ-010 cdb_valid  out  1  head entry present.
REQ-011 cdb_tag  out  TAG_W  head tag.
REQ-012 cdb_data  out  DATA_W  head result.
REQ-013 full  out  1  count equals DEPTH.
REQ-014 empty  out  1  count equals 0.
REQ-015 count  out  $clog2(DEPTH)+1  number of stored entries.
REQ-016 overflow  out  1  sticky flag, set when a write is dropped.

Function
REQ-017 The block SHALL be a first-word-fall-through FIFO: cdb_valid = !empty; cdb_tag and cdb_data SHALL show the head entry combinationally from storage.
REQ-018 When cdb_valid=0, cdb_tag SHALL be 4'b1111 and cdb_data SHALL be 0.
REQ-019 pop = cdb_grant && cdb_valid; a grant while empty SHALL be ignored.
REQ-020 push = wr_en && wr_tag != 4'b1111 && (!full || pop); a write carrying the no-tag value SHALL be discarded without setting overflow.
REQ-021 Write latency: a pushed entry SHALL first appear at the head on the cycle after the write edge, when the FIFO was empty.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged, including when the FIFO is full.
REQ-023 A write with a valid tag while full and without pop SHALL be dropped, and overflow SHALL be set on the next edge and held until reset.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; entries SHALL leave in write order.
REQ-025 full, empty and count SHALL be registered or derived from registered state; they SHALL have no combinational path from wr_en or cdb_grant.

Reset
REQ-026 When reset=1 at a rising edge, pointers, count and overflow SHALL clear. Outputs SHALL then read empty=1, full=0, count=0, cdb_valid=0, cdb_tag=4'b1111, cdb_data=0.
REQ-027 Reset SHALL take priority over any push or pop in the same cycle; that write SHALL be lost.
REQ-028 Storage contents need not be cleared.

Configuration
REQ-029 Macro CDB_FIFO_BYPASS_EN.
- Defined: when empty=1 and a valid push occurs, cdb_valid SHALL assert in the same cycle, with cdb_tag=wr_tag and cdb_data=wr_data. If cdb_grant is also 1, the entry SHALL be consumed and not stored, and count SHALL stay 0.
- Undefined: no bypass; REQ-021 applies.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset, then wr_en=1, wr_tag=3, wr_data=32'h0000_0005 for one cycle, no grant -> next cycle: cdb_valid=1, cdb_tag=3, cdb_data=5, count=1 (bypass build: visible in the write cycle itself).
REQ-031 Write tags 0..7 on consecutive cycles with DEPTH=8 -> full=1, count=8. A further write of tag 9 -> dropped, overflow=1. Grant 8 cycles -> tags 0..7 in order, then empty=1 and overflow still 1.
REQ-032 Full FIFO, simultaneous wr_en (tag 2) and cdb_grant -> count stays 8; tag 2 is emitted last; overflow stays 0.
REQ-033 cdb_grant=1 while empty -> no state change, cdb_tag=4'b1111. wr_en with wr_tag=4'b1111 -> ignored, count=0, overflow=0.
REQ-034 Three entries stored, reset asserted with a concurrent write of tag 5 -> next cycle count=0, empty=1, overflow=0, cdb_valid=0.
REQ-035 Bypass build: empty FIFO, wr_en (tag 6, data 32'h10) with cdb_grant in the same cycle -> cdb_valid=1, cdb_tag=6, cdb_data=32'h10 that cycle; next cycle count=0.
